// File: rtl/rv_loader_pkg.sv
// rv_loader_pkg: shared states and constants for the instruction-memory loader.
// RV_IMEM_LOADER_CHECKSUM_EN adds the CSUM state.
package rv_loader_pkg;
  localparam int LDR_HDR_BYTES = 2;
  localparam int LDR_WORD_BYTES = 4;
  localparam logic [7:0] LDR_CSUM_INIT = 8'h00;
  typedef enum logic [2:0] {
    LDR_HDR_LO,
    LDR_HDR_HI,
    LDR_WORD,
    LDR_WRITE,
    LDR_DONE,
    LDR_ERR
`ifdef RV_IMEM_LOADER_CHECKSUM_EN
    , LDR_CSUM
`endif
  } loader_state_e;
endpackage

// File: rtl/rv_byte_packer.sv
// rv_byte_packer: byte index counter and little-endian 32-bit word assembly register.
module rv_byte_packer
  import rv_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic        word_valid
);
  logic [1:0]  idx_q, idx_d;
  logic [31:0] word_q, word_d;
  always_comb begin
    idx_d = clr ? 2'd0 : idx_q + 2'(en);
    word_d = word_q;
    if (en) word_d[{idx_q, 3'b000} +: 8] = data;
    if (clr) word_d = '0;
  end
  assign word_valid = en & (idx_q == 2'(LDR_WORD_BYTES - 1));
  assign word = word_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= '0;
      word_q <= '0;
    end else begin
      idx_q <= idx_d;
      word_q <= word_d;
    end
  end
endmodule

// File: rtl/rv_imem_loader.sv
// rv_imem_loader: boot loader streaming a counted byte image into instruction memory.
// RV_IMEM_LOADER_CHECKSUM_EN appends an XOR checksum byte to the image.
module rv_imem_loader
  import rv_loader_pkg::*;
#(
  parameter int DW = 64,
  parameter int IMEM_DEPTH = 256
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_valid,
  input  logic [7:0]    s_data,
  output logic          s_ready,
  input  logic          load_req,
  output logic          imem_we,
  output logic [DW-1:0] imem_addr,
  output logic [31:0]   imem_wdata,
  output logic          cpu_rst_n,
  output logic          done,
  output logic          err
);
  localparam int CW = LDR_HDR_BYTES * 8;
  loader_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, widx_q, widx_d, n_hdr;
  logic          xfer, word_valid;
  logic [31:0]   word;
`ifdef RV_IMEM_LOADER_CHECKSUM_EN
  localparam loader_state_e LDR_FIN = LDR_CSUM;
  logic [7:0] csum_q, csum_d;
  assign s_ready = state_q inside {LDR_HDR_LO, LDR_HDR_HI, LDR_WORD, LDR_CSUM};
  always_comb begin
    csum_d = (state_q inside {LDR_DONE, LDR_ERR} && load_req) ? LDR_CSUM_INIT :
             (state_q == LDR_WORD && xfer) ? csum_q ^ s_data : csum_q;
  end
  always_ff @(posedge clk) csum_q <= rst ? LDR_CSUM_INIT : csum_d;
`else
  localparam loader_state_e LDR_FIN = LDR_DONE;
  assign s_ready = state_q inside {LDR_HDR_LO, LDR_HDR_HI, LDR_WORD};
`endif
  assign xfer = s_valid & s_ready;
  assign n_hdr = {s_data, cnt_q[7:0]};
  rv_byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clr        (state_q == LDR_HDR_HI),
    .en         (xfer && state_q == LDR_WORD),
    .data       (s_data),
    .word       (word),
    .word_valid (word_valid)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    widx_d = widx_q;
    case (state_q)
      LDR_HDR_LO: if (xfer) begin
        cnt_d[7:0] = s_data;
        state_d = LDR_HDR_HI;
      end
      LDR_HDR_HI: if (xfer) begin
        cnt_d = n_hdr;
        widx_d = '0;
        state_d = n_hdr == '0 ? LDR_FIN : 32'(n_hdr) > 32'(IMEM_DEPTH) ? LDR_ERR : LDR_WORD;
      end
      LDR_WORD: if (word_valid) state_d = LDR_WRITE;
      LDR_WRITE: begin
        widx_d = widx_q + 1'b1;
        state_d = widx_d == cnt_q ? LDR_FIN : LDR_WORD;
      end
      LDR_DONE, LDR_ERR: if (load_req) state_d = LDR_HDR_LO;
`ifdef RV_IMEM_LOADER_CHECKSUM_EN
      LDR_CSUM: if (xfer) state_d = s_data == csum_q ? LDR_DONE : LDR_ERR;
`endif
      default: state_d = LDR_HDR_LO;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LDR_HDR_LO;
      cnt_q <= '0;
      widx_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      widx_q <= widx_d;
    end
  end
  assign imem_we = state_q == LDR_WRITE;
  assign imem_addr = {{(DW - CW - 2){1'b0}}, widx_q, 2'b00};
  assign imem_wdata = word;
  assign cpu_rst_n = state_q == LDR_DONE;
  assign done = state_q == LDR_DONE;
  assign err = state_q == LDR_ERR;
endmodule

// File: tb/tb_rv_imem_loader.sv
// tb_rv_imem_loader: directed tests for the instruction-memory loader.
module tb_rv_imem_loader;
  logic        clk = 0, rst = 1, s_valid = 0, load_req = 0;
  logic [7:0]  s_data = 0;
  logic        s_ready, imem_we, cpu_rst_n, done, err;
  logic [63:0] imem_addr;
  logic [31:0] imem_wdata;
  int          checks = 0, errors = 0, rdy_bad = 0;
  logic [63:0] wa[$];
  logic [31:0] wd[$];
  logic [7:0]  bq[$];

  always #5 clk = ~clk;

  rv_imem_loader #(.DW(64), .IMEM_DEPTH(256)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .load_req(load_req), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_rst_n(cpu_rst_n), .done(done), .err(err)
  );

  always @(negedge clk) begin
    if (imem_we) begin
      wa.push_back(imem_addr);
      wd.push_back(imem_wdata);
    end
    if (!rst && !s_ready && !imem_we && !done && !err) rdy_bad++;
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1; s_valid = 0; load_req = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    wa.delete(); wd.delete(); rdy_bad = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t = 0;
    s_valid = 1; s_data = b;
    while (!s_ready && t < 20) begin @(negedge clk); t++; end
    if (!s_ready) begin
      checks++; errors++;
      $display("FAIL send_byte timeout byte=%h s_ready=%b expected 1", b, s_ready);
      s_valid = 0;
      return;
    end
    @(negedge clk);
    s_valid = 0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_image(input int gap);
    logic [7:0] x = 8'h00;
    foreach (bq[i]) begin
      send_byte(bq[i], gap);
      if (i >= 2) x ^= bq[i];
    end
`ifdef RV_IMEM_LOADER_CHECKSUM_EN
    send_byte(x, gap);
`endif
  endtask

  task automatic wait_done(input string name);
    int t = 0;
    while (!done && t < 50) begin @(negedge clk); t++; end
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL %s done timeout got %b expected 1", name, done); end
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) @(negedge clk);
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset s_ready got %b expected 1", s_ready); end
    checks++; if (imem_we !== 1'b0) begin errors++; $display("FAIL reset imem_we got %b expected 0", imem_we); end
    checks++; if (imem_addr !== 64'h0) begin errors++; $display("FAIL reset imem_addr got %h expected 0", imem_addr); end
    checks++; if (imem_wdata !== 32'h0) begin errors++; $display("FAIL reset imem_wdata got %h expected 0", imem_wdata); end
    checks++; if (cpu_rst_n !== 1'b0) begin errors++; $display("FAIL reset cpu_rst_n got %b expected 0", cpu_rst_n); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset done got %b expected 0", done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset err got %b expected 0", err); end
    rst = 0;
  endtask

  task automatic test_full_rate();
    do_reset();
    bq = {8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    send_image(0);
`ifndef RV_IMEM_LOADER_CHECKSUM_EN
    checks++; if (imem_we !== 1'b1) begin errors++; $display("FAIL full_we_latency got %b expected 1", imem_we); end
    checks++; if (cpu_rst_n !== 1'b0) begin errors++; $display("FAIL full_cpu_rst_in_write got %b expected 0", cpu_rst_n); end
    @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL full_done_next got %b expected 1", done); end
    checks++; if (cpu_rst_n !== 1'b1) begin errors++; $display("FAIL full_cpu_rst_n_next got %b expected 1", cpu_rst_n); end
`endif
    wait_done("full");
    checks++; if (wa.size() !== 2) begin errors++; $display("FAIL full_count got %0d expected 2", wa.size()); end
    if (wa.size() >= 2) begin
      checks++; if (wa[0] !== 64'h0 || wd[0] !== 32'h00000013) begin errors++; $display("FAIL full_w0 got %h@%h expected 00000013@0", wd[0], wa[0]); end
      checks++; if (wa[1] !== 64'h4 || wd[1] !== 32'h00100093) begin errors++; $display("FAIL full_w1 got %h@%h expected 00100093@4", wd[1], wa[1]); end
    end
  endtask

  task automatic test_stalled();
    do_reset();
    bq = {8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    send_image(3);
    wait_done("stall");
    checks++; if (wa.size() !== 2) begin errors++; $display("FAIL stall_count got %0d expected 2", wa.size()); end
    if (wa.size() >= 2) begin
      checks++; if (wa[0] !== 64'h0 || wd[0] !== 32'h00000013) begin errors++; $display("FAIL stall_w0 got %h@%h expected 00000013@0", wd[0], wa[0]); end
      checks++; if (wa[1] !== 64'h4 || wd[1] !== 32'h00100093) begin errors++; $display("FAIL stall_w1 got %h@%h expected 00100093@4", wd[1], wa[1]); end
    end
    checks++; if (rdy_bad !== 0) begin errors++; $display("FAIL stall_ready_drop got %0d expected 0", rdy_bad); end
  endtask

  task automatic test_zero();
    do_reset();
    bq = {8'h00, 8'h00};
    send_image(0);
    wait_done("zero");
    checks++; if (wa.size() !== 0) begin errors++; $display("FAIL zero_writes got %0d expected 0", wa.size()); end
  endtask

  task automatic test_overflow();
    do_reset();
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL ovf_err got %b expected 1", err); end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL ovf_s_ready got %b expected 0", s_ready); end
    checks++; if (cpu_rst_n !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL ovf_cpu got cpu_rst_n=%b done=%b expected 0 0", cpu_rst_n, done); end
    repeat (3) @(negedge clk);
    checks++; if (wa.size() !== 0 || err !== 1'b1) begin errors++; $display("FAIL ovf_hold got writes=%0d err=%b expected 0 1", wa.size(), err); end
    load_req = 1;
    @(negedge clk);
    load_req = 0;
    checks++; if (err !== 1'b0 || s_ready !== 1'b1) begin errors++; $display("FAIL ovf_reload got err=%b s_ready=%b expected 0 1", err, s_ready); end
    bq = {8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    send_image(0);
    wait_done("ovf_recover");
    checks++; if (wa.size() !== 1) begin errors++; $display("FAIL ovf_count got %0d expected 1", wa.size()); end
    if (wa.size() >= 1) begin
      checks++; if (wa[0] !== 64'h0 || wd[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL ovf_w0 got %h@%h expected deadbeef@0", wd[0], wa[0]); end
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    send_byte(8'h02, 0); send_byte(8'h00, 0); send_byte(8'hAA, 0); send_byte(8'hBB, 0);
    rst = 1;
    @(negedge clk);
    rst = 0;
    checks++; if (s_ready !== 1'b1 || cpu_rst_n !== 1'b0) begin errors++; $display("FAIL midrst_state got s_ready=%b cpu_rst_n=%b expected 1 0", s_ready, cpu_rst_n); end
    checks++; if (imem_wdata !== 32'h0) begin errors++; $display("FAIL midrst_partial got %h expected 0", imem_wdata); end
    repeat (4) @(negedge clk);
    checks++; if (wa.size() !== 0 || cpu_rst_n !== 1'b0) begin errors++; $display("FAIL midrst_nowrite got writes=%0d cpu_rst_n=%b expected 0 0", wa.size(), cpu_rst_n); end
    bq = {8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
    send_image(0);
    wait_done("midrst");
    checks++; if (wa.size() !== 1) begin errors++; $display("FAIL midrst_count got %0d expected 1", wa.size()); end
    if (wa.size() >= 1) begin
      checks++; if (wa[0] !== 64'h0 || wd[0] !== 32'h12345678) begin errors++; $display("FAIL midrst_w0 got %h@%h expected 12345678@0", wd[0], wa[0]); end
    end
  endtask

  task automatic test_reload();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL reload_pre_done got %b expected 1", done); end
    wa.delete(); wd.delete();
    load_req = 1;
    @(negedge clk);
    load_req = 0;
    checks++; if (cpu_rst_n !== 1'b0 || done !== 1'b0 || s_ready !== 1'b1) begin errors++; $display("FAIL reload_drop got cpu_rst_n=%b done=%b s_ready=%b expected 0 0 1", cpu_rst_n, done, s_ready); end
    bq = {8'h01, 8'h00, 8'h67, 8'h45, 8'h23, 8'h01};
    send_image(0);
    wait_done("reload");
    checks++; if (wa.size() !== 1) begin errors++; $display("FAIL reload_count got %0d expected 1", wa.size()); end
    if (wa.size() >= 1) begin
      checks++; if (wa[0] !== 64'h0 || wd[0] !== 32'h01234567) begin errors++; $display("FAIL reload_w0 got %h@%h expected 01234567@0", wd[0], wa[0]); end
    end
  endtask

  task automatic test_max_depth();
    logic [7:0] b;
    do_reset();
    bq = {8'h00, 8'h01};
    for (int i = 0; i < 256; i++) begin
      b = 8'(i);
      bq.push_back(b); bq.push_back(~b); bq.push_back(8'h3C); bq.push_back(8'hC3);
    end
    send_image(0);
    wait_done("max");
    checks++; if (wa.size() !== 256) begin errors++; $display("FAIL max_count got %0d expected 256", wa.size()); end
    if (wa.size() == 256) begin
      for (int i = 0; i < 256; i++) begin
        b = 8'(i);
        checks++;
        if (wa[i] !== 64'(i * 4) || wd[i] !== {8'hC3, 8'h3C, ~b, b}) begin
          errors++; $display("FAIL max_w%0d got %h@%h expected %h@%h", i, wd[i], wa[i], {8'hC3, 8'h3C, ~b, b}, 64'(i * 4));
        end
      end
    end
  endtask

`ifdef RV_IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    do_reset();
    bq = {8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00};
    foreach (bq[i]) send_byte(bq[i], 0);
    send_byte(8'h13, 0);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL csum_ok got done=%b expected 1", done); end
    do_reset();
    foreach (bq[i]) send_byte(bq[i], 0);
    send_byte(8'h12, 0);
    checks++; if (err !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL csum_bad got err=%b done=%b expected 1 0", err, done); end
  endtask
`endif

  initial begin
    test_reset();
    test_full_rate();
    test_stalled();
    test_zero();
    test_overflow();
    test_mid_reset();
    test_reload();
    test_max_depth();
`ifdef RV_IMEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
